// File: rtl/fft_stage_sequencer.sv
// FFT stage sequencer: walks an N-point radix-2 transform through SIZE
// stages, launching the stage address generator once per stage, waiting
// for its completion, draining the butterfly pipeline and flipping the
// ping-pong bank between stages.
module fft_stage_sequencer #(
  parameter int N       = 16,
  parameter int SIZE    = 4,
  parameter int DRAIN   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            stage_done,
  output logic            start_stage,
  output logic [SIZE-1:0] stage_idx,
  output logic            bank_sel,
  output logic            busy,
  output logic            fft_done,
  output logic            timeout_err
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int DW = $clog2(DRAIN + 1);

  localparam logic [TW-1:0]   TMO_MAX  = TW'(TIMEOUT - 1);
  localparam logic [DW-1:0]   DRN_LOAD = DW'(DRAIN - 1);
  localparam logic [SIZE-1:0] LAST     = SIZE'(SIZE);

  // Length and stage count are redundant; only SIZE drives the logic.
  if (N != (1 << SIZE)) begin : g_len_mismatch
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_RUN, S_DRAIN, S_DONE
  } st_e;

  st_e             state_q, state_d;
  logic [SIZE-1:0] stage_q, stage_d;
  logic            bank_q, bank_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [DW-1:0]   drn_q, drn_d;
  logic            ss_q, ss_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            terr_q, terr_d;

  // Next state and next registered outputs; pulses default low so every
  // exit path (abort, timeout, completion) cleanly drops them.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bank_d  = bank_q;
    tmo_d   = tmo_q;
    drn_d   = drn_q;
    ss_d    = 1'b0;
    done_d  = 1'b0;
    terr_d  = 1'b0;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      stage_d = '0;
      tmo_d   = '0;
      drn_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          stage_d = '0;
          if (start && !abort) begin
            state_d = S_LAUNCH;
            stage_d = SIZE'(1);
            bank_d  = 1'b0;
            ss_d    = 1'b1;
          end
        end
        S_LAUNCH: begin
          state_d = S_RUN;
          tmo_d   = '0;
        end
        S_RUN: begin
          // completion beats a coincident timeout
          if (stage_done) begin
            state_d = S_DRAIN;
            drn_d   = DRN_LOAD;
          end else if (tmo_q == TMO_MAX) begin
            state_d = S_IDLE;
            stage_d = '0;
            tmo_d   = '0;
            terr_d  = 1'b1;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        S_DRAIN: begin
          if (drn_q == '0) begin
            bank_d = ~bank_q;
            if (stage_q < LAST) begin
              state_d = S_LAUNCH;
              stage_d = stage_q + SIZE'(1);
              ss_d    = 1'b1;
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end else begin
            drn_d = drn_q - DW'(1);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          stage_d = '0;
        end
        default: begin
          state_d = S_IDLE;
          stage_d = '0;
        end
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // State, counters and all outputs registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      bank_q  <= 1'b0;
      tmo_q   <= '0;
      drn_q   <= '0;
      ss_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      bank_q  <= bank_d;
      tmo_q   <= tmo_d;
      drn_q   <= drn_d;
      ss_q    <= ss_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
    end
  end

  assign start_stage = ss_q;
  assign stage_idx   = stage_q;
  assign bank_sel    = bank_q;
  assign busy        = busy_q;
  assign fft_done    = done_q;
  assign timeout_err = terr_q;

endmodule
